// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: single-outstanding req/ack fetcher feeding a small FIFO
// whose head word and address drive the control unit's instruction input.
module instr_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic                         clk_i,
  input  logic                         r_i,
  input  logic                         pc_load_i,
  input  logic [AW-1:0]                pc_value_i,
  output logic                         mem_req_o,
  output logic [AW-1:0]                mem_addr_o,
  input  logic                         mem_ack_i,
  input  logic [15:0]                  mem_data_i,
  output logic [15:0]                  instr_o,
  output logic [AW-1:0]                instr_pc_o,
  output logic                         instr_valid_o,
  input  logic                         instr_take_i,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DISCARD
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   fetch_addr_q, fetch_addr_d;
  logic [AW-1:0]   disc_addr_q, disc_addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [15:0]     data_mem_q [DEPTH];
  logic [AW-1:0]   addr_mem_q [DEPTH];
  logic            push, pop;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    disc_addr_d  = disc_addr_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    push         = 1'b0;
    pop          = 1'b0;

    if (pc_load_i) begin
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      fetch_addr_d = pc_value_i;
      unique case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          // An unacked request must complete before the new address goes out.
          if (!mem_ack_i) begin
            state_d     = S_DISCARD;
            disc_addr_d = fetch_addr_q;
          end
        end
        S_DISCARD: if (mem_ack_i) state_d = S_FETCH;
        default: state_d = S_IDLE;
      endcase
    end else begin
      pop  = instr_take_i && (count_q != '0);
      push = (state_q == S_FETCH) && mem_ack_i;
      if (push) begin
        wr_ptr_d     = wr_ptr_q + PW'(1);
        fetch_addr_d = fetch_addr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      unique case (state_q)
        // A pop while full frees a slot, so fetching resumes straight away.
        S_IDLE:    if (count_d < FULL) state_d = S_FETCH;
        S_FETCH:   if (push && (count_d == FULL)) state_d = S_IDLE;
        S_DISCARD: if (mem_ack_i) state_d = S_FETCH;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!r_i) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= '0;
      disc_addr_q  <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      disc_addr_q  <= disc_addr_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // Storage needs no reset: reads are masked by the entry count.
  always_ff @(posedge clk_i) begin
    if (r_i && push) begin
      data_mem_q[wr_ptr_q] <= mem_data_i;
      addr_mem_q[wr_ptr_q] <= fetch_addr_q;
    end
  end

  assign mem_req_o     = (state_q != S_IDLE);
  assign mem_addr_o    = (state_q == S_DISCARD) ? disc_addr_q : fetch_addr_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? data_mem_q[rd_ptr_q] : 16'h0000;
  assign instr_pc_o    = instr_valid_o ? addr_mem_q[rd_ptr_q] : '0;
  assign level_o       = count_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: fill, pop, redirect/discard, wrap and reset.
module tb_instr_prefetch_queue;

  logic        clk_i = 1'b0;
  logic        r_i = 1'b0;
  logic        pc_load_i = 1'b0;
  logic [15:0] pc_value_i = '0;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [15:0] mem_data_i = '0;
  logic [15:0] instr_o;
  logic [15:0] instr_pc_o;
  logic        instr_valid_o;
  logic        instr_take_i = 1'b0;
  logic [2:0]  level_o;

  int total = 0;
  int bad   = 0;

  instr_prefetch_queue #(.DEPTH(4), .AW(16)) dut (
    .clk_i         (clk_i),
    .r_i           (r_i),
    .pc_load_i     (pc_load_i),
    .pc_value_i    (pc_value_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_take_i  (instr_take_i),
    .level_o       (level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic ack, input logic [15:0] data, input logic take,
                      input logic pcl, input logic [15:0] pcv);
    mem_ack_i    = ack;
    mem_data_i   = data;
    instr_take_i = take;
    pc_load_i    = pcl;
    pc_value_i   = pcv;
    @(posedge clk_i);
    #1;
    mem_ack_i    = 1'b0;
    instr_take_i = 1'b0;
    pc_load_i    = 1'b0;
  endtask

  // Zero-wait memory: acks whatever is requested with data = addr ^ A5A5.
  task automatic auto_step(input logic take);
    step(mem_req_o, mem_addr_o ^ 16'hA5A5, take, 1'b0, 16'h0000);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_instr", 32'(instr_o), 32'd0);
    chk("rst_pc", 32'(instr_pc_o), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    r_i = 1'b1;
    chk("idle_req", 32'(mem_req_o), 32'd0);

    // Fill with zero-wait memory
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("fill_req0", 32'(mem_req_o), 32'd1);
    chk("fill_addr0", 32'(mem_addr_o), 32'h0000);
    auto_step(1'b0);
    chk("fill_addr1", 32'(mem_addr_o), 32'h0001);
    chk("fill_lvl1", 32'(level_o), 32'd1);
    chk("fill_instr1", 32'(instr_o), 32'hA5A5);
    auto_step(1'b0);
    chk("fill_addr2", 32'(mem_addr_o), 32'h0002);
    auto_step(1'b0);
    chk("fill_addr3", 32'(mem_addr_o), 32'h0003);
    chk("fill_lvl3", 32'(level_o), 32'd3);
    auto_step(1'b0);
    chk("full_lvl", 32'(level_o), 32'd4);
    chk("full_req", 32'(mem_req_o), 32'd0);
    chk("full_instr", 32'(instr_o), 32'hA5A5);
    chk("full_pc", 32'(instr_pc_o), 32'h0000);
    chk("full_valid", 32'(instr_valid_o), 32'd1);

    // One take from full
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    chk("take_lvl", 32'(level_o), 32'd3);
    chk("take_instr", 32'(instr_o), 32'hA5A4);
    chk("take_pc", 32'(instr_pc_o), 32'h0001);
    chk("take_req", 32'(mem_req_o), 32'd1);
    chk("take_addr", 32'(mem_addr_o), 32'h0004);

    // Take without ack brings level to 2, then take+ack together
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    chk("lvl2", 32'(level_o), 32'd2);
    chk("lvl2_instr", 32'(instr_o), 32'hA5A7);
    auto_step(1'b1);
    chk("both_lvl", 32'(level_o), 32'd2);
    chk("both_instr", 32'(instr_o), 32'hA5A6);
    chk("both_pc", 32'(instr_pc_o), 32'h0003);
    chk("both_addr", 32'(mem_addr_o), 32'h0005);

    // Redirect to 0100 with request to 5 pending; ack 3 cycles late
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100);
    chk("disc_req", 32'(mem_req_o), 32'd1);
    chk("disc_addr_a", 32'(mem_addr_o), 32'h0005);
    chk("disc_lvl", 32'(level_o), 32'd0);
    chk("disc_valid", 32'(instr_valid_o), 32'd0);
    chk("disc_instr", 32'(instr_o), 32'h0000);
    chk("disc_pc", 32'(instr_pc_o), 32'h0000);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    chk("empty_take_lvl", 32'(level_o), 32'd0);
    chk("disc_addr_b", 32'(mem_addr_o), 32'h0005);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("disc_addr_c", 32'(mem_addr_o), 32'h0005);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0000);
    chk("redir_req", 32'(mem_req_o), 32'd1);
    chk("redir_addr", 32'(mem_addr_o), 32'h0100);
    chk("redir_lvl", 32'(level_o), 32'd0);
    chk("redir_valid", 32'(instr_valid_o), 32'd0);
    auto_step(1'b0);
    chk("redir_head_valid", 32'(instr_valid_o), 32'd1);
    chk("redir_head_pc", 32'(instr_pc_o), 32'h0100);
    chk("redir_head_instr", 32'(instr_o), 32'hA4A5);
    chk("redir_head_lvl", 32'(level_o), 32'd1);
    chk("redir_next_addr", 32'(mem_addr_o), 32'h0101);

    // Redirect to FFFE coinciding with an ack (data dropped), then wrap
    step(1'b1, 16'h1234, 1'b0, 1'b1, 16'hFFFE);
    chk("wrap_addr0", 32'(mem_addr_o), 32'hFFFE);
    chk("wrap_lvl0", 32'(level_o), 32'd0);
    chk("wrap_req0", 32'(mem_req_o), 32'd1);
    auto_step(1'b0);
    chk("wrap_pc_a", 32'(instr_pc_o), 32'hFFFE);
    chk("wrap_instr_a", 32'(instr_o), 32'h5A5B);
    chk("wrap_addr1", 32'(mem_addr_o), 32'hFFFF);
    chk("wrap_lvl1", 32'(level_o), 32'd1);
    auto_step(1'b0);
    chk("wrap_addr2", 32'(mem_addr_o), 32'h0000);
    auto_step(1'b0);
    chk("wrap_addr3", 32'(mem_addr_o), 32'h0001);
    auto_step(1'b0);
    chk("wrap_full_lvl", 32'(level_o), 32'd4);
    chk("wrap_full_req", 32'(mem_req_o), 32'd0);
    chk("wrap_full_pc", 32'(instr_pc_o), 32'hFFFE);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    chk("wrap_pop_pc1", 32'(instr_pc_o), 32'hFFFF);
    chk("wrap_pop_instr1", 32'(instr_o), 32'h5A5A);
    chk("wrap_refetch_addr", 32'(mem_addr_o), 32'h0002);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    chk("wrap_pop_pc2", 32'(instr_pc_o), 32'h0000);
    chk("wrap_pop_instr2", 32'(instr_o), 32'hA5A5);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    chk("wrap_pop_pc3", 32'(instr_pc_o), 32'h0001);
    chk("wrap_pop_lvl3", 32'(level_o), 32'd1);

    // Reset mid-fetch at level 3, with an ack during reset
    auto_step(1'b0);
    auto_step(1'b0);
    chk("pre_rst_lvl", 32'(level_o), 32'd3);
    chk("pre_rst_addr", 32'(mem_addr_o), 32'h0004);
    r_i = 1'b0;
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000);
    chk("mid_rst_req", 32'(mem_req_o), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr_o), 32'd0);
    chk("mid_rst_instr", 32'(instr_o), 32'd0);
    chk("mid_rst_pc", 32'(instr_pc_o), 32'd0);
    chk("mid_rst_valid", 32'(instr_valid_o), 32'd0);
    chk("mid_rst_lvl", 32'(level_o), 32'd0);
    r_i = 1'b1;
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("post_rst_req", 32'(mem_req_o), 32'd1);
    chk("post_rst_addr", 32'(mem_addr_o), 32'h0000);
    chk("post_rst_lvl", 32'(level_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
